motor_drive_decoder: RTL

// - Receive-side decoder for the two-wire H-bridge drive pair {rev, fwd} produced by
//   the motor control stage: drive[0]=fwd = PWM & ~dir, drive[1]=rev = PWM & dir.
// - Over a fixed window of WINDOW clocks it recovers the duty count, the direction and

---
 rtl/motor_drive_decoder.sv | 104 ++++++++++
 1 files changed

// File: rtl/motor_drive_decoder.sv
// Receive-side decoder for the {rev, fwd} H-bridge drive pair: recovers duty count,
// majority direction and a sticky shoot-through fault over fixed windows of WINDOW clocks.
module motor_drive_decoder #(
  parameter int WINDOW = 256,
  parameter int CNT_W  = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       drive,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] duty,
  output logic             dir,
  output logic             valid,
  output logic             fault
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] rev_cnt_q, rev_cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;

  logic             inc_f, inc_r, close;
  logic [CNT_W-1:0] fwd_fin, rev_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      wcnt_q    <= '0;
      fwd_cnt_q <= '0;
      rev_cnt_q <= '0;
      duty_q    <= '0;
      dir_q     <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      wcnt_q    <= wcnt_d;
      fwd_cnt_q <= fwd_cnt_d;
      rev_cnt_q <= rev_cnt_d;
      duty_q    <= duty_d;
      dir_q     <= dir_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    sync1_d   = drive;
    sync2_d   = sync1_q;
    wcnt_d    = wcnt_q;
    fwd_cnt_d = fwd_cnt_q;
    rev_cnt_d = rev_cnt_q;
    duty_d    = duty_q;
    dir_d     = dir_q;
    valid_d   = 1'b0;

    inc_f   = (sync2_q == 2'b01);
    inc_r   = (sync2_q == 2'b10);
    // Close-cycle sample belongs to the window being reported.
    fwd_fin = fwd_cnt_q + {{(CNT_W-1){1'b0}}, inc_f};
    rev_fin = rev_cnt_q + {{(CNT_W-1){1'b0}}, inc_r};
    close   = en && (wcnt_q == LAST);

    if (!en) begin
      wcnt_d    = '0;
      fwd_cnt_d = '0;
      rev_cnt_d = '0;
    end else if (close) begin
      wcnt_d    = '0;
      fwd_cnt_d = '0;
      rev_cnt_d = '0;
      duty_d    = fwd_fin + rev_fin;
      valid_d   = 1'b1;
      if (rev_fin > fwd_fin) begin
        dir_d = 1'b1;
      end else if (fwd_fin > rev_fin) begin
        dir_d = 1'b0;
      end
    end else begin
      wcnt_d    = wcnt_q + 1'b1;
      fwd_cnt_d = fwd_fin;
      rev_cnt_d = rev_fin;
    end

    // A shoot-through sample outranks a simultaneous clear.
    fault_d = (sync2_q == 2'b11) | (fault_q & ~fault_clr);
  end

  assign duty  = duty_q;
  assign dir   = dir_q;
  assign valid = valid_q;
  assign fault = fault_q;

endmodule
